// File: rtl/rr_replay_pkt_decoder_pkg.sv
// rr_replay_pkg: shared widths, FSM states and width-table helpers for the replay decoder
package rr_replay_pkg;

    localparam int RR_CHANNEL_WIDTH_BITS = 8;
    localparam int RR_MAX_CH = 64;

    typedef logic [RR_MAX_CH-1:0][RR_CHANNEL_WIDTH_BITS-1:0] width_tab_t;

    typedef enum logic [1:0] {ST_IDLE, ST_DISPATCH, ST_END} state_t;

    localparam logic [13:0][RR_CHANNEL_WIDTH_BITS-1:0] RR_SHUFFLED_CHANNEL_WIDTHS = {
        8'd12, 8'd8, 8'd32, 8'd4, 8'd16, 8'd8, 8'd24,
        8'd1, 8'd8, 8'd16, 8'd32, 8'd2, 8'd8, 8'd64
    };

    function automatic int max_ch_width(input width_tab_t w);
        int m = 0;
        for (int i = 0; i < RR_MAX_CH; i++) m = (int'(w[i]) > m) ? int'(w[i]) : m;
        return m;
    endfunction

    function automatic int sum_widths(input width_tab_t w);
        int s = 0;
        for (int i = 0; i < RR_MAX_CH; i++) s += int'(w[i]);
        return s;
    endfunction

    // Payload bits occupied by set channels below n; n = RR_MAX_CH gives the full payload length.
    function automatic int ch_offset(input width_tab_t w, input logic [RR_MAX_CH-1:0] b, input int n);
        int s = 0;
        for (int j = 0; j < RR_MAX_CH; j++) s += (j < n && b[j]) ? int'(w[j]) : 0;
        return s;
    endfunction

endpackage

// File: rtl/rr_replay_pkt_decoder_if.sv
// rr_replay_pkt_decoder_if: replay packet input and per-channel event output bundle
interface rr_replay_pkt_decoder_if import rr_replay_pkg::*; #(
    parameter int LOGB_CHANNEL_CNT = 14,
    parameter int LOGE_CHANNEL_CNT = 25,
    parameter logic [LOGB_CHANNEL_CNT-1:0][RR_CHANNEL_WIDTH_BITS-1:0] SHUFFLED_CHANNEL_WIDTHS = RR_SHUFFLED_CHANNEL_WIDTHS
) ();
    localparam width_tab_t W_TAB = width_tab_t'(SHUFFLED_CHANNEL_WIDTHS);
    localparam int WIDTH = LOGB_CHANNEL_CNT + LOGE_CHANNEL_CNT + sum_widths(W_TAB);
    localparam int OFFSET_WIDTH = $clog2(WIDTH + 1);
    localparam int MAX_CH_WIDTH = max_ch_width(W_TAB);

    logic                                             pkt_valid;
    logic                                             pkt_ready;
    logic [WIDTH-1:0]                                 pkt;
    logic [OFFSET_WIDTH-1:0]                          pkt_width;
    logic [LOGB_CHANNEL_CNT-1:0]                      logb_valid;
    logic [LOGB_CHANNEL_CNT-1:0]                      logb_ready;
    logic [LOGB_CHANNEL_CNT-1:0][MAX_CH_WIDTH-1:0]    logb_data;
    logic [LOGE_CHANNEL_CNT-1:0]                      loge_valid;
    logic [LOGE_CHANNEL_CNT-1:0]                      loge_ready;

    modport master (
        output pkt_valid, pkt, pkt_width, logb_ready, loge_ready,
        input  pkt_ready, logb_valid, logb_data, loge_valid
    );

    modport slave (
        input  pkt_valid, pkt, pkt_width, logb_ready, loge_ready,
        output pkt_ready, logb_valid, logb_data, loge_valid
    );

endinterface

// File: rtl/rr_replay_pkt_decoder_extract.sv
// rr_pkt_extract: combinational prefix-sum lane extraction and packet length from a packed replay packet
module rr_pkt_extract import rr_replay_pkg::*; #(
    parameter int LOGB_CHANNEL_CNT = 14,
    parameter int LOGE_CHANNEL_CNT = 25,
    parameter logic [LOGB_CHANNEL_CNT-1:0][RR_CHANNEL_WIDTH_BITS-1:0] SHUFFLED_CHANNEL_WIDTHS = RR_SHUFFLED_CHANNEL_WIDTHS,
    localparam width_tab_t W_TAB = width_tab_t'(SHUFFLED_CHANNEL_WIDTHS),
    localparam int HDR = LOGB_CHANNEL_CNT + LOGE_CHANNEL_CNT,
    localparam int WIDTH = HDR + sum_widths(W_TAB),
    localparam int OFFSET_WIDTH = $clog2(WIDTH + 1),
    localparam int MAX_CH_WIDTH = max_ch_width(W_TAB)
) (
    input  logic [WIDTH-1:0]                              i_pkt,
    output logic [LOGB_CHANNEL_CNT-1:0][MAX_CH_WIDTH-1:0] o_lanes,
    output logic [OFFSET_WIDTH-1:0]                       o_len
);
    logic [RR_MAX_CH-1:0] w_bits;

    assign w_bits = RR_MAX_CH'(i_pkt[LOGB_CHANNEL_CNT-1:0]);
    assign o_len  = OFFSET_WIDTH'(HDR + ch_offset(W_TAB, w_bits, RR_MAX_CH));

    for (genvar i = 0; i < LOGB_CHANNEL_CNT; i++) begin : g_lane
        localparam int W = int'(W_TAB[i]);
        localparam logic [MAX_CH_WIDTH-1:0] MASK = {MAX_CH_WIDTH{1'b1}} >> (MAX_CH_WIDTH - W);
        assign o_lanes[i] = w_bits[i]
            ? (MAX_CH_WIDTH'(i_pkt >> (HDR + ch_offset(W_TAB, w_bits, i))) & MASK)
            : '0;
    end

endmodule

// File: rtl/rr_replay_pkt_decoder.sv
// rr_replay_pkt_decoder: splits replay packets into per-channel logb/loge events held until consumed
module rr_replay_pkt_decoder import rr_replay_pkg::*; #(
    parameter int LOGB_CHANNEL_CNT = 14,
    parameter int LOGE_CHANNEL_CNT = 25,
    parameter logic [LOGB_CHANNEL_CNT-1:0][RR_CHANNEL_WIDTH_BITS-1:0] SHUFFLED_CHANNEL_WIDTHS = RR_SHUFFLED_CHANNEL_WIDTHS
) (
    input  logic                   clk,
    input  logic                   rst_n,
    rr_replay_pkt_decoder_if.slave io_bus,
    output logic                   o_trace_end,
    output logic                   o_len_error,
    output logic [31:0]            o_pkt_cnt
);
    localparam width_tab_t W_TAB = width_tab_t'(SHUFFLED_CHANNEL_WIDTHS);
    localparam int LB = LOGB_CHANNEL_CNT;
    localparam int HDR = LOGB_CHANNEL_CNT + LOGE_CHANNEL_CNT;
    localparam int WIDTH = HDR + sum_widths(W_TAB);
    localparam int OFFSET_WIDTH = $clog2(WIDTH + 1);
    localparam int MAX_CH_WIDTH = max_ch_width(W_TAB);

    state_t                                       r_state, w_state_nxt;
    logic [LB-1:0]                                r_pend_b, w_pend_b_nxt;
    logic [LOGE_CHANNEL_CNT-1:0]                  r_pend_e, w_pend_e_nxt;
    logic [LB-1:0][MAX_CH_WIDTH-1:0]              r_lanes, w_lanes;
    logic [OFFSET_WIDTH-1:0]                      w_len;
    logic [31:0]                                  r_pkt_cnt;
    logic                                         r_trace_end, r_len_error;
    logic                                         w_accept, w_hdr_zero, w_drained;

    rr_pkt_extract #(
        .LOGB_CHANNEL_CNT       (LOGB_CHANNEL_CNT),
        .LOGE_CHANNEL_CNT       (LOGE_CHANNEL_CNT),
        .SHUFFLED_CHANNEL_WIDTHS(SHUFFLED_CHANNEL_WIDTHS)
    ) u_extract (
        .i_pkt  (io_bus.pkt),
        .o_lanes(w_lanes),
        .o_len  (w_len)
    );

    assign io_bus.logb_valid = r_pend_b;
    assign io_bus.loge_valid = r_pend_e;
    assign io_bus.logb_data  = r_lanes;
    assign o_trace_end       = r_trace_end;
    assign o_len_error       = r_len_error;
    assign o_pkt_cnt         = r_pkt_cnt;

    // Next state, upstream ready and next pending masks; a new packet may reload masks as the last events drain.
    always_comb begin
        w_drained        = ~|(r_pend_b & ~io_bus.logb_ready) && ~|(r_pend_e & ~io_bus.loge_ready);
        io_bus.pkt_ready = rst_n && (r_state == ST_IDLE || (r_state == ST_DISPATCH && w_drained));
        w_accept         = io_bus.pkt_valid && io_bus.pkt_ready;
        w_hdr_zero       = ~|io_bus.pkt[HDR-1:0];
        w_pend_b_nxt     = w_accept ? (w_hdr_zero ? '0 : io_bus.pkt[LB-1:0]) : (r_pend_b & ~io_bus.logb_ready);
        w_pend_e_nxt     = w_accept ? (w_hdr_zero ? '0 : io_bus.pkt[HDR-1:LB]) : (r_pend_e & ~io_bus.loge_ready);
        w_state_nxt      = w_accept ? (w_hdr_zero ? ST_END : ST_DISPATCH)
                         : (r_state == ST_DISPATCH && w_drained) ? ST_IDLE : r_state;
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Pending masks, held lanes, packet counter and sticky status flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend_b    <= '0;
            r_pend_e    <= '0;
            r_lanes     <= '0;
            r_pkt_cnt   <= '0;
            r_trace_end <= 1'b0;
            r_len_error <= 1'b0;
        end else begin
            r_pend_b <= w_pend_b_nxt;
            r_pend_e <= w_pend_e_nxt;
            if (w_accept && !w_hdr_zero) begin
                r_lanes   <= w_lanes;
                r_pkt_cnt <= r_pkt_cnt + 32'd1;
            end
            if (w_accept && w_len > io_bus.pkt_width) r_len_error <= 1'b1;
            if (w_accept && w_hdr_zero) r_trace_end <= 1'b1;
        end
    end

endmodule

// File: tb/tb_rr_replay_pkt_decoder.sv
// tb_rr_replay_pkt_decoder: randomized self-checking bench for the replay packet decoder (3 logb, 2 loge channels)
module tb_rr_replay_pkt_decoder;
    import rr_replay_pkg::*;

    localparam int LB = 3;
    localparam int LE = 2;
    localparam int HB = LB + LE;
    localparam int PW = 33;
    localparam logic [LB-1:0][RR_CHANNEL_WIDTH_BITS-1:0] TW = {8'd8, 8'd4, 8'd16};
    localparam int TWI [LB] = '{16, 4, 8};

    logic        clk = 1'b0;
    logic        rst_n;
    logic        o_trace_end, o_len_error;
    logic [31:0] o_pkt_cnt;
    int          total = 0, bad = 0, exp_cnt = 0;

    rr_replay_pkt_decoder_if #(.LOGB_CHANNEL_CNT(LB), .LOGE_CHANNEL_CNT(LE), .SHUFFLED_CHANNEL_WIDTHS(TW)) bus ();

    rr_replay_pkt_decoder #(.LOGB_CHANNEL_CNT(LB), .LOGE_CHANNEL_CNT(LE), .SHUFFLED_CHANNEL_WIDTHS(TW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .io_bus     (bus),
        .o_trace_end(o_trace_end),
        .o_len_error(o_len_error),
        .o_pkt_cnt  (o_pkt_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Walks the packet left to right: each set logb channel consumes its width from a running position.
    function automatic void model(input logic [PW-1:0] p, output logic [LB-1:0][15:0] l, output int n);
        int pos = HB;
        l = '0;
        for (int i = 0; i < LB; i++)
            if (p[i]) begin
                for (int k = 0; k < TWI[i]; k++) l[i][k] = p[pos+k];
                pos += TWI[i];
            end
        n = pos;
    endfunction

    function automatic logic [PW-1:0] rnd_pkt();
        logic [PW-1:0] p;
        p = PW'({$urandom(), $urandom()});
        while (p[HB-1:0] == '0) p[HB-1:0] = HB'($urandom());
        return p;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [PW-1:0] p, input logic [5:0] w);
        bus.pkt       = p;
        bus.pkt_width = w;
        bus.pkt_valid = 1'b1;
    endtask

    task automatic chk_pkt(input string tag, input logic [PW-1:0] p);
        logic [LB-1:0][15:0] l;
        int n;
        model(p, l, n);
        check({tag, ".logb_v"}, 64'(bus.logb_valid), 64'(p[LB-1:0]));
        check({tag, ".loge_v"}, 64'(bus.loge_valid), 64'(p[HB-1:LB]));
        check({tag, ".data"}, 64'(bus.logb_data), 64'(l));
        check({tag, ".cnt"}, 64'(o_pkt_cnt), 64'(exp_cnt));
    endtask

    initial begin
        logic [PW-1:0] p, q;
        logic [LB-1:0][15:0] l;
        int n;
        rst_n          = 1'b1;
        bus.pkt_valid  = 1'b0;
        bus.pkt        = '0;
        bus.pkt_width  = '0;
        bus.logb_ready = '1;
        bus.loge_ready = '1;
        #1 rst_n = 1'b0;
        #2;
        check("rst.ready", 64'(bus.pkt_ready), 64'(0));
        check("rst.logb_v", 64'(bus.logb_valid), 64'(0));
        check("rst.loge_v", 64'(bus.loge_valid), 64'(0));
        check("rst.end", 64'(o_trace_end), 64'(0));
        check("rst.cnt", 64'(o_pkt_cnt), 64'(0));
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        #1 check("idle.ready", 64'(bus.pkt_ready), 64'(1));

        p = '0;
        p[2:0] = 3'b101;
        p[4:3] = 2'b10;
        p[20:5] = 16'hBEEF;
        p[28:21] = 8'h5A;
        send(p, 6'd32);
        tick();
        exp_cnt++;
        bus.pkt_valid = 1'b0;
        chk_pkt("basic", p);
        check("basic.lane0", 64'(bus.logb_data[0]), 64'hBEEF);
        check("basic.lane1", 64'(bus.logb_data[1]), 64'h0);
        check("basic.lane2", 64'(bus.logb_data[2]), 64'h5A);
        check("basic.lenerr", 64'(o_len_error), 64'(0));
        tick();

        p = rnd_pkt();
        send(p, 6'd33);
        for (int k = 0; k < 10; k++) begin
            #1 check("b2b.ready", 64'(bus.pkt_ready), 64'(1));
            tick();
            exp_cnt++;
            chk_pkt("b2b", p);
            if (k < 9) begin
                p = rnd_pkt();
                send(p, 6'd33);
            end else bus.pkt_valid = 1'b0;
        end
        check("b2b.lenerr", 64'(o_len_error), 64'(0));
        tick();

        p = rnd_pkt();
        p[HB-1:0] = 5'b00111;
        model(p, l, n);
        bus.logb_ready = 3'b011;
        send(p, 6'd33);
        tick();
        exp_cnt++;
        chk_pkt("bp", p);
        q = rnd_pkt();
        send(q, 6'd33);
        for (int k = 0; k < 5; k++) begin
            #1;
            check("bp.ready", 64'(bus.pkt_ready), 64'(0));
            check("bp.lane2", 64'(bus.logb_data[2]), 64'(l[2]));
            tick();
            check("bp.logb_v", 64'(bus.logb_valid), 64'(3'b100));
        end
        bus.logb_ready = '1;
        #1 check("bp.release", 64'(bus.pkt_ready), 64'(1));
        tick();
        exp_cnt++;
        bus.pkt_valid = 1'b0;
        chk_pkt("bp.next", q);
        tick();

        p = rnd_pkt();
        p[LB-1:0] = 3'b111;
        send(p, 6'd20);
        tick();
        exp_cnt++;
        bus.pkt_valid = 1'b0;
        check("len.err", 64'(o_len_error), 64'(1));
        chk_pkt("len", p);
        tick();
        p = rnd_pkt();
        send(p, 6'd33);
        tick();
        exp_cnt++;
        bus.pkt_valid = 1'b0;
        check("len.sticky", 64'(o_len_error), 64'(1));
        chk_pkt("len.next", p);
        tick();

        bus.logb_ready = '0;
        bus.loge_ready = '0;
        p = rnd_pkt();
        p[LB-1:0] = 3'b011;
        send(p, 6'd33);
        tick();
        exp_cnt++;
        bus.pkt_valid = 1'b0;
        check("mid.logb_v", 64'(bus.logb_valid), 64'(3'b011));
        #2 rst_n = 1'b0;
        #1;
        exp_cnt = 0;
        check("mid.logb_v0", 64'(bus.logb_valid), 64'(0));
        check("mid.loge_v0", 64'(bus.loge_valid), 64'(0));
        check("mid.data0", 64'(bus.logb_data), 64'(0));
        check("mid.cnt0", 64'(o_pkt_cnt), 64'(exp_cnt));
        check("mid.lenerr0", 64'(o_len_error), 64'(0));
        check("mid.ready0", 64'(bus.pkt_ready), 64'(0));
        @(posedge clk);
        #1 rst_n = 1'b1;
        bus.logb_ready = '1;
        bus.loge_ready = '1;
        #1;
        check("mid.ready1", 64'(bus.pkt_ready), 64'(1));
        check("mid.logb_v1", 64'(bus.logb_valid), 64'(0));

        send('0, 6'd32);
        tick();
        send(rnd_pkt(), 6'd33);
        #1;
        check("term.end", 64'(o_trace_end), 64'(1));
        check("term.ready", 64'(bus.pkt_ready), 64'(0));
        check("term.logb_v", 64'(bus.logb_valid), 64'(0));
        check("term.loge_v", 64'(bus.loge_valid), 64'(0));
        check("term.cnt", 64'(o_pkt_cnt), 64'(exp_cnt));
        repeat (3) tick();
        check("term.hold_ready", 64'(bus.pkt_ready), 64'(0));
        check("term.hold_cnt", 64'(o_pkt_cnt), 64'(exp_cnt));
        check("term.hold_end", 64'(o_trace_end), 64'(1));
        check("term.hold_v", 64'(bus.logb_valid), 64'(0));
        bus.pkt_valid = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
